// File: rtl/lab9_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lab9_reset_sequencer
//  Description : Avalon-MM slave owning the board reset pushbutton and the
//                downstream reset domains of the lab9 SoC. Synchronizes and
//                debounces the raw key, exposes level / press edge-capture
//                with an optional interrupt, and runs a staged reset
//                sequence (assert all, release one domain at a time).
//  Ports       : clk, reset_n      - clock, async active-low reset
//                key_n             - raw pushbutton, 0 = pressed
//                avs_*             - Avalon-MM slave, 1-cycle read latency
//                irq               - EDGE[0] & irq_en
//                rst_out_n         - domain resets, bit 0 released first
//                busy              - sequencer not idle
//  Registers   : 0 DATA(RO) 1 CTRL(RW) 2 EDGE(W1C) 3 STATUS(RO)
//  Revision    : 1.0 - initial release
// ============================================================================
module lab9_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_STAGES      = 3,
    parameter int HOLD_CYCLES     = 64,
    parameter int STAGE_GAP       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_n,
    input  logic [1:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic                  irq,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  busy
);

    localparam int C_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int C_CNT_MX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int C_CNT_W  = (C_CNT_MX > 1) ? $clog2(C_CNT_MX) : 1;
    localparam int C_K_W    = $clog2(NUM_STAGES + 1);

    localparam logic [C_DB_W-1:0]  C_DB_LAST   = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(STAGE_GAP - 1);
    localparam logic [C_K_W-1:0]   C_K_DONE    = C_K_W'(NUM_STAGES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_HOLD    = 2'b01,
        S_RELEASE = 2'b10
    } state_t;

    // ------------------------------------------------------------------------
    // Key synchronizer and debouncer
    // ------------------------------------------------------------------------
    logic              r_sync1, r_sync2, r_db, r_db_d;
    logic [C_DB_W-1:0] r_db_cnt;
    logic              w_press;

    // The counter only runs while a level change is pending, so any glitch
    // shorter than DEBOUNCE_CYCLES collapses back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_db     <= 1'b1;
            r_db_d   <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == C_DB_LAST) begin
                r_db     <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + C_DB_W'(1);
            end
        end
    end

    assign w_press = r_db_d & ~r_db;

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    logic       r_irq_en, r_auto_en, r_edge;
    logic [7:0] r_count;
    logic       w_wr_ctrl, w_sw_trig, w_edge_clr, w_start;

    assign w_wr_ctrl  = avs_write && (avs_address == 2'd1);
    assign w_sw_trig  = w_wr_ctrl && avs_writedata[2];
    assign w_edge_clr = avs_write && (avs_address == 2'd2) && avs_writedata[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en  <= 1'b0;
            r_auto_en <= 1'b1;
            r_edge    <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en  <= avs_writedata[0];
                r_auto_en <= avs_writedata[1];
            end
            // A press in the same cycle as a clear must not be lost.
            if (w_press) begin
                r_edge <= 1'b1;
            end else if (w_edge_clr) begin
                r_edge <= 1'b0;
            end
            if (w_press && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reset sequencer FSM
    // ------------------------------------------------------------------------
    state_t                r_state, w_state_nxt;
    logic [C_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [C_K_W-1:0]      r_k, w_k_nxt;
    logic [NUM_STAGES-1:0] r_rst_n, w_rst_n_nxt;

    assign w_start = (w_press && r_auto_en) || w_sw_trig;

    // Power-on lands directly in RELEASE so the domains come up in order
    // without any software involvement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RELEASE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_rst_n <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_rst_n <= w_rst_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_rst_n_nxt = r_rst_n;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_k_nxt     = '0;
                w_rst_n_nxt = '1;
                if (w_start) begin
                    w_state_nxt = S_HOLD;
                    w_rst_n_nxt = '0;
                end
            end
            S_HOLD: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            S_RELEASE: begin
                // r_k == NUM_STAGES means the last domain was released on
                // the previous edge.
                if (r_k == C_K_DONE) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_GAP_LAST) begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (r_k == C_K_W'(i)) begin
                            w_rst_n_nxt[i] = 1'b1;
                        end
                    end
                    w_k_nxt   = r_k + C_K_W'(1);
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_k_nxt     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read path and outputs
    // ------------------------------------------------------------------------
    logic [31:0] r_rdata, w_rdata;
    logic        w_unused;

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            2'd0: w_rdata[0]    = ~r_db;
            2'd1: w_rdata[1:0]  = {r_auto_en, r_irq_en};
            2'd2: w_rdata[0]    = r_edge;
            2'd3: begin
                w_rdata[0]    = (r_state != S_IDLE);
                w_rdata[2:1]  = r_state;
                w_rdata[15:8] = r_count;
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (avs_read) begin
            r_rdata <= w_rdata;
        end
    end

    assign w_unused     = ^avs_writedata[31:3];
    assign avs_readdata = r_rdata;
    assign irq          = r_edge & r_irq_en;
    assign rst_out_n    = r_rst_n;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lab9_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab9_reset_sequencer
//  Description : Self-checking bench for lab9_reset_sequencer using small
//                parameters (debounce 8, 3 stages, hold 5, gap 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lab9_reset_sequencer;

    localparam int TB_DB   = 8;
    localparam int TB_NS   = 3;
    localparam int TB_HOLD = 5;
    localparam int TB_GAP  = 4;

    logic             clk = 1'b0;
    logic             reset_n, key_n, avs_read, avs_write;
    logic [1:0]       avs_address;
    logic [31:0]      avs_writedata, avs_readdata;
    logic             irq, busy;
    logic [TB_NS-1:0] rst_out_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       key_n;
        logic [2:0] rst;
        logic       busy;
    } po_vec_t;

    po_vec_t po_tbl [13];

    lab9_reset_sequencer #(
        .DEBOUNCE_CYCLES (TB_DB),
        .NUM_STAGES      (TB_NS),
        .HOLD_CYCLES     (TB_HOLD),
        .STAGE_GAP       (TB_GAP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_n         (key_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .rst_out_n     (rst_out_n),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Expected {busy, rst_out_n} n cycles after HOLD entry (n < 0: idle).
    function automatic logic [3:0] exp_seq(input int n);
        logic [3:0] r;
        if (n < 0) return 4'b0111;
        r[3] = (n <= TB_HOLD + TB_NS * TB_GAP);
        for (int k = 0; k < TB_NS; k++) r[k] = (n >= TB_HOLD + (k + 1) * TB_GAP);
        return r;
    endfunction

    task automatic seq_check(input string tag, input int i, input int entry, input logic exp_irq);
        logic [3:0] e;
        e = exp_seq(i - entry);
        check($sformatf("%s_rst@%0d", tag, i), 32'(rst_out_n), 32'(e[2:0]));
        check($sformatf("%s_busy@%0d", tag, i), 32'(busy), 32'(e[3]));
        check($sformatf("%s_irq@%0d", tag, i), 32'(irq), 32'(exp_irq));
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_power_on(input string tag);
        for (int j = 0; j < 13; j++) begin
            key_n = po_tbl[j].key_n;
            @(negedge clk);
            check($sformatf("%s_rst[%0d]", tag, j), 32'(rst_out_n), 32'(po_tbl[j].rst));
            check($sformatf("%s_busy[%0d]", tag, j), 32'(busy), 32'(po_tbl[j].busy));
        end
    endtask

    initial begin : main
        logic [31:0] d;
        int          first;
        int          bad;

        po_tbl[0]  = '{1'b1, 3'b000, 1'b1};
        po_tbl[1]  = '{1'b1, 3'b000, 1'b1};
        po_tbl[2]  = '{1'b1, 3'b000, 1'b1};
        po_tbl[3]  = '{1'b1, 3'b001, 1'b1};
        po_tbl[4]  = '{1'b1, 3'b001, 1'b1};
        po_tbl[5]  = '{1'b1, 3'b001, 1'b1};
        po_tbl[6]  = '{1'b1, 3'b001, 1'b1};
        po_tbl[7]  = '{1'b1, 3'b011, 1'b1};
        po_tbl[8]  = '{1'b1, 3'b011, 1'b1};
        po_tbl[9]  = '{1'b1, 3'b011, 1'b1};
        po_tbl[10] = '{1'b1, 3'b011, 1'b1};
        po_tbl[11] = '{1'b1, 3'b111, 1'b1};
        po_tbl[12] = '{1'b1, 3'b111, 1'b0};

        reset_n = 1'b0; key_n = 1'b1;
        avs_read = 1'b0; avs_write = 1'b0;
        avs_address = 2'd0; avs_writedata = 32'd0;

        // Reset values
        wait_cycles(3);
        check("reset_rst", 32'(rst_out_n), 32'h0);
        check("reset_busy", 32'(busy), 32'h1);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_rdata", avs_readdata, 32'h0);

        // Power-on staged release
        reset_n = 1'b1;
        run_power_on("po");
        avs_rd(2'd1, d); check("ctrl_reset", d, 32'h2);
        avs_rd(2'd2, d); check("edge_reset", d, 32'h0);
        avs_rd(3'd3, d); check("status_idle", d, 32'h0);

        // Bounce: 3-cycle toggles rejected, final hold accepted
        avs_wr(2'd1, 32'h0);
        first = -1; bad = 0;
        for (int c = 0; c < 25; c++) begin
            key_n = (c < 12) ? (((c / 3) % 2) != 0) : 1'b0;
            avs_rd(2'd0, d);
            if (d[0] && first < 0) first = c;
            if (first >= 0 && !d[0]) bad++;
        end
        check("bounce_data_first_cycle", 32'(first), 32'd22);
        check("bounce_data_stable", 32'(bad), 32'd0);
        avs_rd(2'd2, d); check("bounce_edge", d, 32'h1);
        avs_rd(2'd3, d); check("bounce_status", d, 32'h100);
        check("bounce_irq_disabled", 32'(irq), 32'h0);
        key_n = 1'b1;
        wait_cycles(14);
        avs_rd(2'd3, d); check("release_no_event", d, 32'h100);
        avs_wr(2'd2, 32'h1);
        avs_rd(2'd2, d); check("edge_cleared", d, 32'h0);

        // Press with irq_en and auto_en; clear EDGE mid-sequence
        avs_wr(2'd1, 32'h3);
        key_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            seq_check("press", i, 11, (i >= 11) && (i < 21));
            if (i == 20) begin
                avs_address = 2'd2; avs_writedata = 32'h1; avs_write = 1'b1;
            end
            if (i == 21) avs_write = 1'b0;
        end
        avs_rd(2'd3, d); check("press_status", d, 32'h200);
        key_n = 1'b1;
        wait_cycles(14);

        // Software trigger; a second trigger during HOLD is ignored
        avs_address = 2'd1; avs_writedata = 32'h6; avs_write = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            seq_check("sw", i, 1, 1'b0);
            if (i == 1) avs_write = 1'b0;
            if (i == 3) avs_write = 1'b1;
            if (i == 4) avs_write = 1'b0;
        end
        avs_rd(2'd1, d); check("ctrl_trigger_reads0", d, 32'h2);

        // EDGE clear colliding with a press event: set wins
        avs_wr(2'd1, 32'h0);
        key_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 10) begin
                avs_address = 2'd2; avs_writedata = 32'h1; avs_write = 1'b1;
            end
            if (i == 11) avs_write = 1'b0;
        end
        avs_rd(2'd2, d); check("collision_edge", d, 32'h1);
        avs_rd(2'd3, d); check("collision_status", d, 32'h300);
        key_n = 1'b1;
        wait_cycles(14);

        // reset_n asserted during RELEASE with k = 1
        avs_address = 2'd1; avs_writedata = 32'h7; avs_write = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            seq_check("mid", i, 1, 1'b1);
            if (i == 1) avs_write = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        check("midreset_rst", 32'(rst_out_n), 32'h0);
        check("midreset_busy", 32'(busy), 32'h1);
        check("midreset_irq", 32'(irq), 32'h0);
        check("midreset_rdata", avs_readdata, 32'h0);
        wait_cycles(2);
        reset_n = 1'b1;
        run_power_on("restart");
        avs_rd(2'd2, d); check("restart_edge", d, 32'h0);
        avs_rd(2'd3, d); check("restart_status", d, 32'h0);
        avs_rd(2'd1, d); check("restart_ctrl", d, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
